// File: rtl/cpu_trap_ctrl.sv
// cpu_trap_ctrl: machine-mode trap entry / MRET sequencer sharing the CSR file port.
//
// Optional feature macro: CPU_TRAP_MCAUSE_EN
//   defined   -> trap saves mepc, then mcause, then vectors (3 busy cycles)
//   undefined -> trap saves mepc, then vectors (2 busy cycles); trap_cause unused
//
// Ports
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   trap_req, trap_pc, trap_cause  trap request with faulting PC and mcause value
//   mret_req                       MRET request
//   insn_csr_*                     instruction-side CSR access, passed through in IDLE
//   csr_*                          shared CSR file port (combinational read data)
//   redirect_valid, redirect_pc    one-cycle fetch redirect
//   busy                           pipeline stall while a sequence is in flight
module cpu_trap_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        trap_req,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic        mret_req,
   input  logic [11:0] insn_csr_raddr,
   output logic [31:0] insn_csr_rdata,
   input  logic [11:0] insn_csr_waddr,
   input  logic [31:0] insn_csr_wdata,
   input  logic        insn_csr_we,
   output logic        insn_csr_ready,
   output logic [11:0] csr_raddr,
   input  logic [31:0] csr_rdata,
   output logic [11:0] csr_waddr,
   output logic [31:0] csr_wdata,
   output logic        csr_wenable,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [11:0] CSR_MTVEC  = 12'h305;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SAVE_EPC   = 3'd1,
      SAVE_CAUSE = 3'd2,
      VECTOR     = 3'd3,
      MRET       = 3'd4
   } state_t;

   state_t      state;
   logic [29:0] epc_q;     // word-aligned PC; low two bits are always written as zero
   logic        idle_eff;  // reset forces IDLE-like outputs so an aborted sequence emits nothing

`ifdef CPU_TRAP_MCAUSE_EN
   logic [31:0] cause_q;
   logic        unused_in;
   assign unused_in = ^trap_pc[1:0];
`else
   logic        unused_in;
   assign unused_in = ^{trap_pc[1:0], trap_cause};
`endif

   // State register and request latch
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         epc_q   <= '0;
`ifdef CPU_TRAP_MCAUSE_EN
         cause_q <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // trap wins over a simultaneous MRET
               if (trap_req) begin
                  epc_q   <= trap_pc[31:2];
`ifdef CPU_TRAP_MCAUSE_EN
                  cause_q <= trap_cause;
`endif
                  state   <= SAVE_EPC;
               end else if (mret_req) begin
                  state <= MRET;
               end
            end
`ifdef CPU_TRAP_MCAUSE_EN
            SAVE_EPC:   state <= SAVE_CAUSE;
            SAVE_CAUSE: state <= VECTOR;
`else
            SAVE_EPC:   state <= VECTOR;
`endif
            VECTOR:     state <= IDLE;
            MRET:       state <= IDLE;
            default:    state <= IDLE;
         endcase
      end
   end

   assign idle_eff       = rst || (state == IDLE);
   assign insn_csr_rdata = csr_rdata;
   assign redirect_pc    = {csr_rdata[31:2], 2'b00};

   // CSR port steering and status outputs
   always_comb begin
      csr_raddr      = insn_csr_raddr;
      csr_waddr      = insn_csr_waddr;
      csr_wdata      = insn_csr_wdata;
      csr_wenable    = 1'b0;
      insn_csr_ready = 1'b0;
      redirect_valid = 1'b0;
      busy           = 1'b0;
      if (idle_eff) begin
         csr_wenable    = insn_csr_we;
         insn_csr_ready = 1'b1;
      end else begin
         busy = 1'b1;
         case (state)
            SAVE_EPC: begin
               csr_waddr   = CSR_MEPC;
               csr_wdata   = {epc_q, 2'b00};
               csr_wenable = 1'b1;
            end
`ifdef CPU_TRAP_MCAUSE_EN
            SAVE_CAUSE: begin
               csr_waddr   = CSR_MCAUSE;
               csr_wdata   = cause_q;
               csr_wenable = 1'b1;
            end
`endif
            VECTOR: begin
               csr_raddr      = CSR_MTVEC;
               redirect_valid = 1'b1;
            end
            MRET: begin
               csr_raddr      = CSR_MEPC;
               redirect_valid = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_trap_ctrl.sv
// tb_cpu_trap_ctrl: directed self-checking bench for cpu_trap_ctrl with a small CSR file model.
module tb_cpu_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        trap_req, mret_req;
   logic [31:0] trap_pc, trap_cause;
   logic [11:0] insn_csr_raddr, insn_csr_waddr;
   logic [31:0] insn_csr_rdata, insn_csr_wdata;
   logic        insn_csr_we, insn_csr_ready;
   logic [11:0] csr_raddr, csr_waddr;
   logic [31:0] csr_rdata, csr_wdata;
   logic        csr_wenable;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;

   int passed = 0;
   int total  = 0;

   // CSR file model
   logic [31:0] mepc_m   = 32'h0;
   logic [31:0] mcause_m = 32'h0;
   logic [31:0] mtvec_m  = 32'h0;
   int          wr_cnt     = 0;
   int          mcause_wr  = 0;
   int          redir_cnt  = 0;
   logic [31:0] exp_mcause = 32'h0;

   cpu_trap_ctrl dut (
      .clk(clk), .rst(rst),
      .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
      .mret_req(mret_req),
      .insn_csr_raddr(insn_csr_raddr), .insn_csr_rdata(insn_csr_rdata),
      .insn_csr_waddr(insn_csr_waddr), .insn_csr_wdata(insn_csr_wdata),
      .insn_csr_we(insn_csr_we), .insn_csr_ready(insn_csr_ready),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wenable(csr_wenable),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   always #5 clk = ~clk;

   assign csr_rdata = (csr_raddr == 12'h341) ? mepc_m   :
                      (csr_raddr == 12'h342) ? mcause_m :
                      (csr_raddr == 12'h305) ? mtvec_m  : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (csr_wenable) begin
         wr_cnt <= wr_cnt + 1;
         case (csr_waddr)
            12'h341: mepc_m <= csr_wdata;
            12'h342: begin mcause_m <= csr_wdata; mcause_wr <= mcause_wr + 1; end
            12'h305: mtvec_m <= csr_wdata;
            default: ;
         endcase
      end
      if (redirect_valid) redir_cnt <= redir_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      nxt();
      insn_csr_we = 1'b1; insn_csr_waddr = a; insn_csr_wdata = d;
      nxt();
      insn_csr_we = 1'b0;
   endtask

   // Trap sequence; acc_wr / epc_wr drive an instruction write of mtvec=0x200
   // in the acceptance cycle / the SAVE_EPC cycle respectively.
   task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] exp_epc, input logic [31:0] exp_vec,
                          input bit with_mret, input bit acc_wr, input bit epc_wr);
      int r0;
      r0 = redir_cnt;
      nxt();
      trap_req = 1'b1; mret_req = with_mret; trap_pc = pc; trap_cause = cause;
      insn_csr_we = acc_wr; insn_csr_waddr = 12'h305; insn_csr_wdata = 32'h200;
      #1;
      chkb("acc_busy", busy, 1'b0);
      chkb("acc_ready", insn_csr_ready, 1'b1);
      chkb("acc_we", csr_wenable, acc_wr);
      nxt();
      trap_req = 1'b0; mret_req = 1'b0;
      insn_csr_we = epc_wr;
      #1;
      chkb("epc_busy", busy, 1'b1);
      chkb("epc_ready", insn_csr_ready, 1'b0);
      chkb("epc_we", csr_wenable, 1'b1);
      chk("epc_waddr", 32'(csr_waddr), 32'h341);
      chk("epc_wdata", csr_wdata, exp_epc);
      chkb("epc_rv", redirect_valid, 1'b0);
`ifdef CPU_TRAP_MCAUSE_EN
      nxt();
      insn_csr_we = 1'b0;
      #1;
      chkb("cause_busy", busy, 1'b1);
      chkb("cause_we", csr_wenable, 1'b1);
      chk("cause_waddr", 32'(csr_waddr), 32'h342);
      chk("cause_wdata", csr_wdata, cause);
      chkb("cause_rv", redirect_valid, 1'b0);
      exp_mcause = cause;
`endif
      nxt();
      insn_csr_we = 1'b0;
      #1;
      chkb("vec_busy", busy, 1'b1);
      chkb("vec_rv", redirect_valid, 1'b1);
      chk("vec_pc", redirect_pc, exp_vec);
      chk("vec_raddr", 32'(csr_raddr), 32'h305);
      chkb("vec_we", csr_wenable, 1'b0);
      nxt();
      #1;
      chkb("post_busy", busy, 1'b0);
      chkb("post_rv", redirect_valid, 1'b0);
      chk("mepc", mepc_m, exp_epc);
      chk("mcause", mcause_m, exp_mcause);
      chk("redir_once", 32'(redir_cnt - r0), 32'd1);
   endtask

   initial begin
      int r0, w0, c0;
      rst = 1'b1; trap_req = 1'b0; mret_req = 1'b0;
      trap_pc = '0; trap_cause = '0;
      insn_csr_raddr = '0; insn_csr_waddr = '0; insn_csr_wdata = '0; insn_csr_we = 1'b0;

      // reset state
      nxt(); #1;
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_rv", redirect_valid, 1'b0);
      chkb("rst_ready", insn_csr_ready, 1'b1);
      nxt();
      rst = 1'b0;
      #1;
      chkb("idle_busy", busy, 1'b0);
      chkb("idle_ready", insn_csr_ready, 1'b1);

      // IDLE pass-through of instruction CSR port
      nxt();
      insn_csr_we = 1'b1; insn_csr_waddr = 12'h305; insn_csr_wdata = 32'h100;
      insn_csr_raddr = 12'h305;
      #1;
      chkb("pt_we", csr_wenable, 1'b1);
      chk("pt_waddr", 32'(csr_waddr), 32'h305);
      chk("pt_wdata", csr_wdata, 32'h100);
      chk("pt_raddr", 32'(csr_raddr), 32'h305);
      chk("pt_rdata_old", insn_csr_rdata, 32'h0);
      nxt();
      insn_csr_we = 1'b0;
      #1;
      chk("pt_rdata_new", insn_csr_rdata, 32'h100);

      // basic trap: pc 0x44, cause 2, mtvec 0x100
      do_trap(32'h44, 32'h2, 32'h44, 32'h100, 1'b0, 1'b0, 1'b0);
      chk("no_mcause_wr", 32'(mcause_wr),
`ifdef CPU_TRAP_MCAUSE_EN
          32'd1
`else
          32'd0
`endif
      );

      // MRET: mepc 0x48, mret_req held into the MRET cycle
      csr_write(12'h341, 32'h48);
      w0 = wr_cnt; r0 = redir_cnt;
      nxt();
      mret_req = 1'b1;
      #1;
      chkb("mret_acc_busy", busy, 1'b0);
      nxt();
      #1;
      chkb("mret_busy", busy, 1'b1);
      chkb("mret_rv", redirect_valid, 1'b1);
      chk("mret_pc", redirect_pc, 32'h48);
      chk("mret_raddr", 32'(csr_raddr), 32'h341);
      chkb("mret_we", csr_wenable, 1'b0);
      chkb("mret_ready", insn_csr_ready, 1'b0);
      nxt();
      mret_req = 1'b0;
      #1;
      chkb("mret_post_busy", busy, 1'b0);
      chkb("mret_post_rv", redirect_valid, 1'b0);
      nxt(); #1;
      chk("mret_no_wr", 32'(wr_cnt - w0), 32'd0);
      chk("mret_redir_once", 32'(redir_cnt - r0), 32'd1);

      // simultaneous trap and MRET: trap wins
      do_trap(32'h80, 32'h5, 32'h80, 32'h100, 1'b1, 1'b0, 1'b0);

      // instruction write during SAVE_EPC is blocked; misaligned PC is aligned
      do_trap(32'h47, 32'h3, 32'h44, 32'h100, 1'b0, 1'b0, 1'b1);
      chk("blocked_mtvec", mtvec_m, 32'h100);

      // instruction write in the acceptance cycle commits and is vectored to
      do_trap(32'h10, 32'h7, 32'h10, 32'h200, 1'b0, 1'b1, 1'b0);
      chk("acc_mtvec", mtvec_m, 32'h200);

      // mtvec low bits are masked
      csr_write(12'h305, 32'h103);
      do_trap(32'h20, 32'h1, 32'h20, 32'h100, 1'b0, 1'b0, 1'b0);

      // reset during SAVE_EPC aborts the sequence
      r0 = redir_cnt; c0 = mcause_wr;
      nxt();
      trap_req = 1'b1; trap_pc = 32'h30; trap_cause = 32'h9;
      nxt();
      trap_req = 1'b0; rst = 1'b1;
      #1;
      chkb("abort_busy", busy, 1'b0);
      chkb("abort_rv", redirect_valid, 1'b0);
      chkb("abort_ready", insn_csr_ready, 1'b1);
      chkb("abort_we", csr_wenable, 1'b0);
      nxt();
      rst = 1'b0;
      #1;
      chkb("abort_idle_busy", busy, 1'b0);
      chkb("abort_idle_rv", redirect_valid, 1'b0);
      nxt(); nxt(); nxt(); #1;
      chk("abort_no_redir", 32'(redir_cnt - r0), 32'd0);
      chk("abort_no_mcause", 32'(mcause_wr - c0), 32'd0);
      chk("abort_mcause_val", mcause_m, exp_mcause);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
